// File: rtl/mem_resp_demux_pkg.sv
// Shared types and helpers for the memory response demultiplexer.
// Port IDs are sized for the largest supported requester count.
package mem_resp_demux_pkg;

    localparam int MAX_PORTS = 16;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_id_t;

    function automatic logic [MAX_PORTS-1:0] onehot(input port_id_t id);
        logic [MAX_PORTS-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/resp_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding request.
// Head is the ID of the oldest request; pointers wrap modulo DEPTH.
module resp_tag_fifo
    import mem_resp_demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [ID_W-1:0] wdata,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking; push+pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_resp_demux.sv
// Routes in-order memory responses back to the requester that issued them.
// Optional checking (resp_err, assertions) is enabled by RESP_DEMUX_CHECK_EN.
module mem_resp_demux
    import mem_resp_demux_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         issue_valid,
    input  logic [$clog2(NUM_PORTS)-1:0] issue_sel,
    output logic                         issue_ready,
    input  logic                         mem_resp,
    input  logic [WIDTH-1:0]             mem_rdata,
    output logic [NUM_PORTS-1:0]         port_resp,
    output logic [WIDTH-1:0]             port_rdata,
    output logic                         resp_err
);

    localparam int ID_W = $clog2(NUM_PORTS);

    logic            full;
    logic            empty;
    logic [ID_W-1:0] head;
    logic            push;
    logic            pop;
    port_id_t        head_id;

    // A push while full is legal only when the head leaves the same cycle.
    assign pop         = mem_resp && !empty;
    assign push        = issue_valid && (!full || pop);
    assign issue_ready = !full;
    assign head_id     = port_id_t'(head);

    resp_tag_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (issue_sel),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Registered decode: one-cycle pulse to the head requester, data held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_resp  <= '0;
            port_rdata <= '0;
        end else begin
            port_resp <= pop ? NUM_PORTS'(onehot(head_id)) : '0;
            if (pop) port_rdata <= mem_rdata;
        end
    end

`ifdef RESP_DEMUX_CHECK_EN
    // Sticky flag for a response that had no outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_err <= 1'b0;
        end else if (mem_resp && empty) begin
            resp_err <= 1'b1;
        end
    end

    a_push_full: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(issue_valid && full && !pop)
    );

    a_sel_range: assert property (
        @(posedge clk) disable iff (!reset_n)
        !issue_valid || (int'(issue_sel) < NUM_PORTS)
    );

    a_resp_onehot: assert property (
        @(posedge clk) disable iff (!reset_n)
        $onehot0(port_resp)
    );
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_demux.sv
// Directed self-checking bench for mem_resp_demux.
// Second instance (16 ports, depth 8) runs a randomized scoreboard test.
module tb_mem_resp_demux;

    localparam int W = 128;

`ifdef RESP_DEMUX_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         issue_valid = 1'b0;
    logic [0:0]   issue_sel = '0;
    logic         issue_ready;
    logic         mem_resp = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic [1:0]   port_resp;
    logic [W-1:0] port_rdata;
    logic         resp_err;

    logic         v16 = 1'b0;
    logic [3:0]   s16 = '0;
    logic         rdy16;
    logic         r16 = 1'b0;
    logic [W-1:0] d16 = '0;
    logic [15:0]  pr16;
    logic [W-1:0] pd16;
    logic         err16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp_demux #(.WIDTH(W), .NUM_PORTS(2), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel),
        .issue_ready (issue_ready),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .port_resp   (port_resp),
        .port_rdata  (port_rdata),
        .resp_err    (resp_err)
    );

    mem_resp_demux #(.WIDTH(W), .NUM_PORTS(16), .DEPTH(8)) dut16 (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (v16),
        .issue_sel   (s16),
        .issue_ready (rdy16),
        .mem_resp    (r16),
        .mem_rdata   (d16),
        .port_resp   (pr16),
        .port_rdata  (pd16),
        .resp_err    (err16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        v16 = 1'b0;
        r16 = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (port_resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_port_resp: got %b want 00", port_resp);
        end
        checks++;
        if (port_rdata !== '0) begin
            errors++;
            $display("FAIL reset_port_rdata: got %h want 0", port_rdata);
        end
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_err: got %b want 0", resp_err);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue_ready: got %b want 1", issue_ready);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] d;
        d = {16{8'hA5}};
        do_reset();
        issue_valid = 1'b1;
        issue_sel = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        mem_resp = 1'b1;
        mem_rdata = d;
        step();
        mem_resp = 1'b0;
        mem_rdata = '0;
        checks++;
        if (port_resp !== 2'b10 || port_rdata !== d) begin
            errors++;
            $display("FAIL single_resp: got %b/%h want 10/%h",
                     port_resp, port_rdata, d);
        end
        step();
        checks++;
        if (port_resp !== 2'b00 || port_rdata !== d) begin
            errors++;
            $display("FAIL single_hold: got %b/%h want 00/%h",
                     port_resp, port_rdata, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [4];
        exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_sel = 1'(i % 2);
            step();
            if (i == 2) begin
                checks++;
                if (issue_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready3: got %b want 1", issue_ready);
                end
            end
        end
        issue_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: got %b want 0", issue_ready);
        end
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1;
            mem_rdata = W'(100 + i);
            step();
            checks++;
            if (port_resp !== exp[i] || port_rdata !== W'(100 + i)) begin
                errors++;
                $display("FAIL b2b_resp%0d: got %b/%0d want %b/%0d",
                         i, port_resp, port_rdata, exp[i], 100 + i);
            end
        end
        mem_resp = 1'b0;
        step();
        checks++;
        if (port_resp !== 2'b00 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got resp %b ready %b want 00/1",
                     port_resp, issue_ready);
        end
    endtask

    task automatic test_full_push_pop();
        logic [0:0] fill [4];
        logic [1:0] exp [4];
        fill = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp = '{2'b10, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_sel = fill[i];
            step();
        end
        issue_sel = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = W'(32'h5555);
        step();
        issue_valid = 1'b0;
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b01 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pp: got resp %b ready %b want 01/0",
                     port_resp, issue_ready);
        end
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1;
            mem_rdata = W'(200 + i);
            step();
            checks++;
            if (port_resp !== exp[i]) begin
                errors++;
                $display("FAIL full_drain%0d: got %b want %b",
                         i, port_resp, exp[i]);
            end
        end
        step();
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b00 || port_rdata !== W'(203)) begin
            errors++;
            $display("FAIL full_extra: got %b/%0d want 00/203",
                     port_resp, port_rdata);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        mem_resp = 1'b1;
        mem_rdata = W'(32'hDEAD);
        step();
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b00 || port_rdata !== '0) begin
            errors++;
            $display("FAIL unexp_empty: got %b/%h want 00/0",
                     port_resp, port_rdata);
        end
        checks++;
        if (resp_err !== ERR_EXP) begin
            errors++;
            $display("FAIL unexp_err: got %b want %b", resp_err, ERR_EXP);
        end
        do_reset();
        issue_valid = 1'b1;
        issue_sel = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = W'(32'hBEEF);
        step();
        issue_valid = 1'b0;
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b00 || resp_err !== ERR_EXP) begin
            errors++;
            $display("FAIL unexp_push: got %b err %b want 00/%b",
                     port_resp, resp_err, ERR_EXP);
        end
        mem_resp = 1'b1;
        mem_rdata = W'(32'hCAFE);
        step();
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b10 || port_rdata !== W'(32'hCAFE)) begin
            errors++;
            $display("FAIL unexp_after: got %b/%h want 10/cafe",
                     port_resp, port_rdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_sel = 1'(i % 2);
            step();
        end
        issue_valid = 1'b0;
        mem_resp = 1'b1;
        mem_rdata = W'(32'h77);
        step();
        mem_resp = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (port_resp !== 2'b00 || port_rdata !== '0 ||
            resp_err !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got %b/%h/%b/%b want 00/0/0/1",
                     port_resp, port_rdata, resp_err, issue_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        mem_resp = 1'b1;
        mem_rdata = W'(32'h88);
        step();
        mem_resp = 1'b0;
        checks++;
        if (port_resp !== 2'b00 || port_rdata !== '0 ||
            resp_err !== ERR_EXP) begin
            errors++;
            $display("FAIL rst_stale: got %b/%h/%b want 00/0/%b",
                     port_resp, port_rdata, resp_err, ERR_EXP);
        end
    endtask

    task automatic test_random16();
        logic [3:0]   q [$];
        logic [15:0]  exp_resp;
        logic [W-1:0] exp_data;
        logic         do_push;
        logic         do_pop;
        int           pops;
        do_reset();
        exp_data = '0;
        pops = 0;
        for (int n = 0; n < 140; n++) begin
            checks++;
            if (rdy16 !== (q.size() < 8)) begin
                errors++;
                $display("FAIL r16_ready%0d: got %b want %b",
                         n, rdy16, q.size() < 8);
            end
            do_pop = (n < 100) ? (q.size() > 0 && $urandom_range(0, 2) != 0)
                               : (q.size() > 0);
            do_push = (n < 100) && $urandom_range(0, 1) == 1 &&
                      (q.size() < 8 || do_pop);
            v16 = do_push;
            s16 = 4'($urandom_range(0, 15));
            r16 = do_pop;
            d16 = {$urandom, $urandom, $urandom, $urandom};
            exp_resp = '0;
            if (do_pop) begin
                exp_resp = 16'(1) << q[0];
                exp_data = d16;
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back(s16);
            step();
            checks++;
            if (pr16 !== exp_resp || pd16 !== exp_data) begin
                errors++;
                $display("FAIL r16_resp%0d: got %h/%h want %h/%h",
                         n, pr16, pd16, exp_resp, exp_data);
            end
        end
        v16 = 1'b0;
        r16 = 1'b0;
        checks++;
        if (err16 !== 1'b0 || q.size() != 0 || pops < 20) begin
            errors++;
            $display("FAIL r16_end: err %b left %0d pops %0d",
                     err16, q.size(), pops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_push_pop();
        test_unexpected();
        test_reset_mid();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
